// File: rtl/surfturf_wb_if.sv
// Wishbone master-port bundle for the SURF/TURF register splitter.
// The master drives the request fields; the interconnect returns the response fields.
interface surfturf_wb_if #(
   parameter int ADR_W = 12,
   parameter int DAT_W = 32
);
   logic               cyc;
   logic               stb;
   logic               we;
   logic [ADR_W-1:0]   adr;
   logic [DAT_W/8-1:0] sel;
   logic [DAT_W-1:0]   dat_w;
   logic               ack;
   logic               err;
   logic               rty;
   logic [DAT_W-1:0]   dat_r;

   modport master (
      output cyc, stb, we, adr, sel, dat_w,
      input  ack, err, rty, dat_r
   );

   modport slave (
      input  cyc, stb, we, adr, sel, dat_w,
      output ack, err, rty, dat_r
   );
endinterface

// File: rtl/surfturf_wb_intercon.sv
// Registered Wishbone splitter: one master fanned out to NUM_SLAVES windows plus an AUX upper half.
// Optional stuck-slave watchdog enabled by defining SURFTURF_WB_INTERCON_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for cyc&stb; request and decode are latched on acceptance
// ACTIVE | selected slave (or none, for an unmapped window) is strobed, awaiting ack/err/abort
// RESP   | one-cycle wb ack or err strobe, slave strobes already low
module surfturf_wb_intercon #(
   parameter int NUM_SLAVES = 8,
   parameter int ADR_W      = 12,
   parameter int SLV_ADR_W  = 6,
   parameter int AUX_ADR_W  = 10,
   parameter int DAT_W      = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                            wb_clk_i,
   input  logic                            wb_rst_n_i,
   surfturf_wb_if.slave                    wb,
   output logic [NUM_SLAVES-1:0]           s_cyc_o,
   output logic [NUM_SLAVES-1:0]           s_stb_o,
   output logic [NUM_SLAVES-1:0]           s_we_o,
   output logic [NUM_SLAVES*SLV_ADR_W-1:0] s_adr_o,
   output logic [NUM_SLAVES*DAT_W/8-1:0]   s_sel_o,
   output logic [NUM_SLAVES*DAT_W-1:0]     s_dat_o,
   input  logic [NUM_SLAVES-1:0]           s_ack_i,
   input  logic [NUM_SLAVES-1:0]           s_err_i,
   input  logic [NUM_SLAVES*DAT_W-1:0]     s_dat_i,
   output logic                            aux_cyc_o,
   output logic                            aux_stb_o,
   output logic                            aux_we_o,
   output logic [AUX_ADR_W-1:0]            aux_adr_o,
   output logic [DAT_W/8-1:0]              aux_sel_o,
   output logic [DAT_W-1:0]                aux_dat_o,
   input  logic                            aux_ack_i,
   input  logic                            aux_err_i,
   input  logic [DAT_W-1:0]                aux_dat_i,
   output logic [15:0]                     err_count_o
);

   localparam int IDX_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int SEL_W     = DAT_W / 8;
   localparam int LAT_ADR_W = (SLV_ADR_W > AUX_ADR_W) ? SLV_ADR_W : AUX_ADR_W;

   if (NUM_SLAVES < 1 || NUM_SLAVES > 2**(ADR_W-1-SLV_ADR_W) || TIMEOUT < 1 || TIMEOUT > 65535)
   begin : g_cfg_bad
      $error("surfturf_wb_intercon: illegal parameter set");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                 state_q, state_d;

   logic [LAT_ADR_W-1:0]   adr_q;
   logic                   we_q;
   logic [SEL_W-1:0]       sel_q;
   logic [DAT_W-1:0]       dat_q;
   logic                   bad_q;
   logic [NUM_SLAVES-1:0]  s_cyc_q;
   logic                   aux_cyc_q;
   logic                   ack_q;
   logic                   err_q;
   logic [DAT_W-1:0]       rdat_q;
   logic [15:0]            err_cnt_q;

   logic                   dec_aux;
   logic                   dec_bad;
   logic [IDX_W-1:0]       dec_idx;
   logic [ADR_W-2:0]       dec_hi;
   logic [NUM_SLAVES-1:0]  dec_onehot;

   logic                   rsp_ack;
   logic                   rsp_err;
   logic [DAT_W-1:0]       rsp_dat;

   logic                   req_go;
   logic                   req_drop;
   logic                   set_ack;
   logic                   set_err;
   logic                   cap_dat;

`ifdef SURFTURF_WB_INTERCON_TIMEOUT_EN
   logic [15:0]            wd_q;
`endif

   // Anything below AUX with index out of range or stray bits above the index field is unmapped.
   always_comb begin
      dec_aux    = wb.adr[ADR_W-1];
      dec_idx    = wb.adr[SLV_ADR_W +: IDX_W];
      dec_hi     = wb.adr[ADR_W-2:0] >> (SLV_ADR_W + IDX_W);
      dec_bad    = !dec_aux && ((int'(dec_idx) >= NUM_SLAVES) || (dec_hi != '0));
      dec_onehot = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         dec_onehot[i] = !dec_aux && !dec_bad && (int'(dec_idx) == i);
      end
   end

   // Responses are qualified by our own strobe, so late acks after abort/timeout fall away.
   always_comb begin
      rsp_ack = aux_cyc_q & aux_ack_i;
      rsp_err = aux_cyc_q & aux_err_i;
      rsp_dat = aux_dat_i;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (s_cyc_q[i]) begin
            rsp_ack = rsp_ack | s_ack_i[i];
            rsp_err = rsp_err | s_err_i[i];
            rsp_dat = s_dat_i[i*DAT_W +: DAT_W];
         end
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      req_go   = 1'b0;
      req_drop = 1'b0;
      set_ack  = 1'b0;
      set_err  = 1'b0;
      cap_dat  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (wb.cyc && wb.stb) begin
               req_go  = 1'b1;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (!wb.cyc) begin
               req_drop = 1'b1;
               state_d  = IDLE;
            end else if (bad_q || rsp_err) begin
               set_err  = 1'b1;
               req_drop = 1'b1;
               state_d  = RESP;
            end else if (rsp_ack) begin
               set_ack  = 1'b1;
               cap_dat  = !we_q;
               req_drop = 1'b1;
               state_d  = RESP;
            end
`ifdef SURFTURF_WB_INTERCON_TIMEOUT_EN
            else if (wd_q == 16'(TIMEOUT)) begin
               set_err  = 1'b1;
               req_drop = 1'b1;
               state_d  = RESP;
            end
`endif
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         adr_q     <= '0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         dat_q     <= '0;
         bad_q     <= 1'b0;
         s_cyc_q   <= '0;
         aux_cyc_q <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rdat_q    <= '0;
         err_cnt_q <= '0;
      end else begin
         if (req_go) begin
            adr_q     <= wb.adr[LAT_ADR_W-1:0];
            we_q      <= wb.we;
            sel_q     <= wb.sel;
            dat_q     <= wb.dat_w;
            bad_q     <= dec_bad;
            s_cyc_q   <= dec_onehot;
            aux_cyc_q <= dec_aux;
         end else if (req_drop) begin
            s_cyc_q   <= '0;
            aux_cyc_q <= 1'b0;
         end
         ack_q <= set_ack;
         err_q <= set_err;
         if (cap_dat) begin
            rdat_q <= rsp_dat;
         end
         if (set_err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
         end
      end
   end

`ifdef SURFTURF_WB_INTERCON_TIMEOUT_EN
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         wd_q <= '0;
      end else if (req_go) begin
         wd_q <= '0;
      end else if (state_q == ACTIVE) begin
         wd_q <= wd_q + 16'd1;
      end
   end
`endif

   // Request fields fan out to every slice; only the one-hot strobe qualifies them.
   assign s_cyc_o     = s_cyc_q;
   assign s_stb_o     = s_cyc_q;
   assign s_we_o      = s_cyc_q & {NUM_SLAVES{we_q}};
   assign s_adr_o     = {NUM_SLAVES{adr_q[SLV_ADR_W-1:0]}};
   assign s_sel_o     = {NUM_SLAVES{sel_q}};
   assign s_dat_o     = {NUM_SLAVES{dat_q}};

   assign aux_cyc_o   = aux_cyc_q;
   assign aux_stb_o   = aux_cyc_q;
   assign aux_we_o    = aux_cyc_q & we_q;
   assign aux_adr_o   = adr_q[AUX_ADR_W-1:0];
   assign aux_sel_o   = sel_q;
   assign aux_dat_o   = dat_q;

   assign wb.ack      = ack_q;
   assign wb.err      = err_q;
   assign wb.rty      = 1'b0;
   assign wb.dat_r    = rdat_q;
   assign err_count_o = err_cnt_q;

endmodule
